// File: rtl/fp_op_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP unit among NREQ requesters, with flush/drain.
// Optional feature: define FP_OP_ARB_PRIO0_EN to give requester 0 absolute priority.
module fp_op_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NREQ       = 4,
  parameter int LATENCY    = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NREQ-1:0]            req_valid_i,
  input  logic [NREQ*2-1:0]          req_op_i,
  input  logic [NREQ*DATA_WIDTH-1:0] req_a_i,
  input  logic [NREQ*DATA_WIDTH-1:0] req_b_i,
  output logic [NREQ-1:0]            req_ready_o,
  output logic                       fu_valid_o,
  output logic [1:0]                 fu_op_o,
  output logic [DATA_WIDTH-1:0]      fu_a_o,
  output logic [DATA_WIDTH-1:0]      fu_b_o,
  input  logic [DATA_WIDTH-1:0]      fu_result_i,
  output logic [NREQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]      rsp_data_o,
  input  logic                       flush_i,
  output logic                       flush_done_o,
  output logic                       busy_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};
`ifdef FP_OP_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   rr_ptr_r;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_next_s;
  logic [LATENCY:0] tag_v_r;
  logic [IW-1:0]   tag_idx_r [0:LATENCY];
  logic            grant_any_s;
  logic [IW-1:0]   grant_idx_s;
  logic [IW-1:0]   scan_s;

  // Grant selection: first valid requester at or above rr_ptr, only in RUN and out of reset.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    scan_s      = '0;
    if ((state_r == ST_RUN) && !rst_i) begin
      for (int i = 0; i < NREQ; i++) begin
        scan_s = IW'((int'(rr_ptr_r) + i) % NREQ);
        if (!grant_any_s && req_valid_i[scan_s]) begin
          grant_any_s = 1'b1;
          grant_idx_s = scan_s;
        end else begin
          grant_any_s = grant_any_s;
        end
      end
`ifdef FP_OP_ARB_PRIO0_EN
      if (req_valid_i[0]) begin
        grant_any_s = 1'b1;
        grant_idx_s = '0;
      end else begin
        grant_any_s = grant_any_s;
      end
`endif
    end else begin
      grant_any_s = 1'b0;
    end
  end

  // One-hot ready decode of the selected requester.
  always_comb begin
    if (grant_any_s) begin
      req_ready_o = ONE_HOT0 << grant_idx_s;
    end else begin
      req_ready_o = '0;
    end
  end

  // In-flight count: an op stops counting as it enters the response stage.
  always_comb begin
    count_next_s = count_r;
    case ({grant_any_s, tag_v_r[LATENCY-1]})
      2'b10:   count_next_s = count_r + 1'b1;
      2'b01:   count_next_s = count_r - 1'b1;
      default: count_next_s = count_r;
    endcase
  end

  // Issue registers, tag pipeline, round-robin pointer and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fu_valid_o <= 1'b0;
      fu_op_o    <= 2'b00;
      fu_a_o     <= '0;
      fu_b_o     <= '0;
      rr_ptr_r   <= '0;
      count_r    <= '0;
      busy_o     <= 1'b0;
      tag_v_r    <= '0;
      for (int i = 0; i <= LATENCY; i++) begin
        tag_idx_r[i] <= '0;
      end
    end else begin
      fu_valid_o <= grant_any_s;
      if (grant_any_s) begin
        fu_op_o <= req_op_i[{grant_idx_s, 1'b0} +: 2];
        fu_a_o  <= req_a_i[int'(grant_idx_s) * DATA_WIDTH +: DATA_WIDTH];
        fu_b_o  <= req_b_i[int'(grant_idx_s) * DATA_WIDTH +: DATA_WIDTH];
      end
      // A priority grant to requester 0 leaves the rotation untouched.
      if (grant_any_s && !(PRIO0 && (grant_idx_s == '0))) begin
        rr_ptr_r <= (grant_idx_s == LAST_IDX) ? '0 : grant_idx_s + 1'b1;
      end
      tag_v_r[0]   <= grant_any_s;
      tag_idx_r[0] <= grant_idx_s;
      for (int i = 1; i <= LATENCY; i++) begin
        tag_v_r[i]   <= tag_v_r[i-1];
        tag_idx_r[i] <= tag_idx_r[i-1];
      end
      count_r <= count_next_s;
      busy_o  <= (count_next_s != '0);
    end
  end

  // Flush FSM with registered drain-complete pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_RUN;
      flush_done_o <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          flush_done_o <= 1'b0;
          if (flush_i) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (count_r == '0) begin
            state_r      <= ST_DONE;
            flush_done_o <= 1'b1;
          end else begin
            flush_done_o <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r      <= ST_RUN;
          flush_done_o <= 1'b0;
        end
        default: begin
          state_r      <= ST_RUN;
          flush_done_o <= 1'b0;
        end
      endcase
    end
  end

  // Response decode; the result bus is zero whenever no response is presented.
  always_comb begin
    if (tag_v_r[LATENCY]) begin
      rsp_valid_o = ONE_HOT0 << tag_idx_r[LATENCY];
      rsp_data_o  = fu_result_i;
    end else begin
      rsp_valid_o = '0;
      rsp_data_o  = '0;
    end
  end

endmodule

// File: doc/fp_op_arbiter.md
FP_OP_ARBITER -- requirements
Module: fp_op_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width (IEEE-754 single).
REQ-002 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter LATENCY, default 3, fixed cycles from FP-unit issue to result (1..8).
REQ-004 SHALL have port clk_i  in  1  sole clock; one clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid_i  in  NREQ  per-requester operation request.
REQ-007 SHALL have port req_op_i  in  NREQ x 2  opcode: 00 add, 01 sub, 10 mul, 11 div.
REQ-008 SHALL have ports req_a_i, req_b_i  in  NREQ x DATA_WIDTH  operands.
REQ-009 SHALL have port req_ready_o  out  NREQ  one-hot grant; handshake = valid & ready.
REQ-010 SHALL have ports fu_valid_o 1, fu_op_o 2, fu_a_o/fu_b_o DATA_WIDTH  out  issue to shared FP unit.
REQ-011 SHALL have port fu_result_i  in  DATA_WIDTH  FP-unit result, valid LATENCY cycles after issue.
REQ-012 SHALL have ports rsp_valid_o  out  NREQ  one-hot; rsp_data_o  out  DATA_WIDTH  shared result bus.
REQ-013 SHALL have ports flush_i in 1 drain request; flush_done_o out 1 drain-complete pulse; busy_o out 1 ops in flight.

Function
REQ-014 SHALL drive req_ready_o combinationally: in RUN, at most one bit set, to the first requester with req_valid_i set scanning from rr_ptr upward modulo NREQ; all zero outside RUN.
REQ-015 SHALL, on handshake of requester k in cycle t, set rr_ptr to (k+1) mod NREQ at t+1; rr_ptr unchanged in cycles without handshake.
REQ-016 SHALL register the granted op/operands: fu_valid_o=1 and fu_op_o/fu_a_o/fu_b_o valid in cycle t+1; fu_valid_o=0 in cycles following no handshake.
REQ-017 SHALL carry a tag (valid bit + requester index) through a LATENCY-deep shift pipeline aligned with issue.
REQ-018 SHALL assert rsp_valid_o[k] in cycle t+1+LATENCY for one cycle, with rsp_data_o = fu_result_i (combinational pass-through) in that cycle.
REQ-019 SHALL sustain one issue per cycle; back-to-back grants to different requesters yield back-to-back responses in grant order.
REQ-020 SHALL maintain in-flight count 0..LATENCY (+1 on issue, -1 on response, both same cycle = unchanged); busy_o = (count != 0).
REQ-021 SHALL implement FSM RUN -> DRAIN on flush_i=1 sampled in RUN; DRAIN issues nothing, pending req_valid_i stay un-granted (not dropped).
REQ-022 SHALL move DRAIN -> DONE when count reaches 0 (including count already 0 on entry: DONE one cycle after DRAIN entry); DONE -> RUN unconditionally after one cycle.
REQ-023 SHALL assert flush_done_o only in DONE (single-cycle pulse); flush_i ignored in DRAIN and DONE.
REQ-024 SHALL let a handshake in the cycle flush_i is sampled in RUN complete normally and be drained.
REQ-025 SHALL hold rsp_data_o = 0 in cycles with no rsp_valid_o bit set.

Reset
REQ-026 SHALL, on rst_i=1 at a clock edge, set state RUN, rr_ptr 0, count 0, all tags invalid, fu_valid_o/fu_op_o/fu_a_o/fu_b_o 0, flush_done_o 0, busy_o 0.
REQ-027 SHALL discard operations in flight at reset: no rsp_valid_o for any op issued before reset; req_ready_o all zero while rst_i=1.

Configuration
REQ-028 SHALL, with macro FP_OP_ARB_PRIO0_EN defined, grant requester 0 whenever req_valid_i[0]=1 in RUN, regardless of rr_ptr, without updating rr_ptr on that grant; other requesters remain round-robin.
REQ-029 SHALL, without FP_OP_ARB_PRIO0_EN, treat requester 0 as an ordinary round-robin participant.

Verification
REQ-030 SHALL cover: reset, then req_valid_i=4'b0100, op=10, a=0x40000000, b=0x40400000 -> req_ready_o=4'b0100 same cycle, fu_valid_o next cycle, rsp_valid_o=4'b0100 with rsp_data_o=fu_result_i 4 cycles after grant (LATENCY=3).
REQ-031 SHALL cover: req_valid_i=4'b1111 held 8 cycles, macro undefined -> grant order 0,1,2,3,0,1,2,3, one per cycle, rsp order identical.
REQ-032 SHALL cover: same stimulus with FP_OP_ARB_PRIO0_EN defined -> requester 0 granted every cycle, requesters 1-3 never granted.
REQ-033 SHALL cover: three issues then flush_i pulse -> no grants until flush_done_o pulses exactly one cycle after last rsp_valid_o; grants resume next cycle.
REQ-034 SHALL cover: flush_i with busy_o=0 -> flush_done_o two cycles after flush_i sampled, requests held meanwhile.
REQ-035 SHALL cover: rst_i asserted with 3 ops in flight -> no rsp_valid_o afterward, busy_o=0, rr_ptr=0 (next grant to lowest valid index).
